// File: rtl/step_command_generator_if.sv
// step_command_generator_if: raw button inputs, step commands and debounced levels
interface step_command_generator_if;
  logic btn_up;
  logic btn_down;
  logic increment;
  logic decrement;
  logic btn_up_db;
  logic btn_down_db;
  modport master (output btn_up, btn_down, input increment, decrement, btn_up_db, btn_down_db);
  modport slave (input btn_up, btn_down, output increment, decrement, btn_up_db, btn_down_db);
endinterface

// File: rtl/step_command_generator.sv
// step_command_generator: debounces up/down buttons into single-cycle step pulses with auto-repeat
module step_command_generator #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input logic clk,
  input logic reset,
  step_command_generator_if.slave bus
);
  localparam int MAX_A = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = MAX_A > REPEAT_RATE ? MAX_A : REPEAT_RATE;
  localparam int CW = $clog2(MAX_P) + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DOWN, LOCKOUT} state_t;
  logic [1:0] w_raw, r_s1, r_s2, r_db, r_db_prev;
  cnt_t r_dcnt [2];
  state_t r_state, w_state_nx;
  cnt_t r_rcnt, w_rcnt_nx;
  logic r_rep, w_rep_nx, r_inc, r_dec, w_inc_nx, w_dec_nx;
  logic w_up, w_dn, w_up_rise, w_dn_rise, w_own, w_opp, w_due;
  assign w_raw = {bus.btn_down, bus.btn_up};
  // index 0 is the up button, index 1 the down button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_db <= '0;
      r_db_prev <= '0;
      for (int b = 0; b < 2; b++) r_dcnt[b] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_db_prev <= r_db;
      for (int b = 0; b < 2; b++) begin
        if (r_s2[b] == r_db[b]) r_dcnt[b] <= '0;
        else if (r_dcnt[b] == cnt_t'(DEBOUNCE_CYCLES)) begin
          r_db[b] <= ~r_db[b];
          r_dcnt[b] <= '0;
        end else r_dcnt[b] <= r_dcnt[b] + 1'b1;
      end
    end
  end
  assign w_up = r_db[0];
  assign w_dn = r_db[1];
  assign w_up_rise = w_up & ~r_db_prev[0];
  assign w_dn_rise = w_dn & ~r_db_prev[1];
  assign w_own = r_state == HOLD_UP ? w_up : w_dn;
  assign w_opp = r_state == HOLD_UP ? w_dn : w_up;
  // r_rcnt holds cycles elapsed since the most recent pulse of the hold
  assign w_due = r_rcnt == (r_rep ? cnt_t'(REPEAT_RATE) : cnt_t'(REPEAT_DELAY));
  always_comb begin
    w_state_nx = r_state;
    w_rcnt_nx = '0;
    w_rep_nx = 1'b0;
    w_inc_nx = 1'b0;
    w_dec_nx = 1'b0;
    case (r_state)
      IDLE:
        if (w_up && w_dn) w_state_nx = LOCKOUT;
        else if (w_up_rise || w_dn_rise) begin
          w_state_nx = w_up_rise ? HOLD_UP : HOLD_DOWN;
          w_inc_nx = w_up_rise;
          w_dec_nx = ~w_up_rise;
          w_rcnt_nx = cnt_t'(1);
        end
      HOLD_UP, HOLD_DOWN:
        if (w_opp) w_state_nx = LOCKOUT;
        else if (!w_own) w_state_nx = IDLE;
        else begin
          w_rep_nx = r_rep | w_due;
          w_rcnt_nx = w_due ? cnt_t'(1) : r_rcnt + 1'b1;
          w_inc_nx = w_due & (r_state == HOLD_UP);
          w_dec_nx = w_due & (r_state == HOLD_DOWN);
        end
      default:
        if (!w_up && !w_dn) w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_rcnt <= '0;
      r_rep <= 1'b0;
      r_inc <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rcnt <= w_rcnt_nx;
      r_rep <= w_rep_nx;
      r_inc <= w_inc_nx;
      r_dec <= w_dec_nx;
    end
  end
  assign bus.increment = r_inc;
  assign bus.decrement = r_dec;
  assign bus.btn_up_db = r_db[0];
  assign bus.btn_down_db = r_db[1];
endmodule

// File: tb/tb_step_command_generator.sv
// tb_step_command_generator: scoreboard against a timeline-based model plus directed pulse-timing checks
module tb_step_command_generator;
  localparam int D = 4, RD = 16, RR = 4;
  localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_LOCK = 3;
  logic clk = 0, reset = 1;
  int n_checks = 0, n_fail = 0, cyc = 0;
  step_command_generator_if bus();
  step_command_generator #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [3:0] expq[$];
  logic hu[$], hd[$];
  int incq[$], decq[$], upr[$];
  int mode = M_IDLE, start = 0;
  logic mdbu = 0, mdbd = 0, pu = 0, pd = 0, last_up = 0;
  // a debounced level flips once the D+1 synchronized samples ending two edges back all differ from it
  function automatic logic flip(input logic h[$], input logic db);
    int n = h.size();
    if (n < D + 3) return 1'b0;
    for (int i = n - 3 - D; i <= n - 3; i++) if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    logic ei, ed, nu, nd;
    int k;
    cyc++;
    ei = 0;
    ed = 0;
    if (reset) begin
      hu.delete(); hd.delete();
      mdbu = 0; mdbd = 0; pu = 0; pd = 0; mode = M_IDLE;
    end else begin
      k = cyc - start;
      if (mode == M_IDLE) begin
        if (mdbu && mdbd) mode = M_LOCK;
        else if (mdbu && !pu) begin mode = M_UP; start = cyc; ei = 1; end
        else if (mdbd && !pd) begin mode = M_DN; start = cyc; ed = 1; end
      end else if (mode == M_LOCK) begin
        if (!mdbu && !mdbd) mode = M_IDLE;
      end else begin
        if (mode == M_UP ? mdbd : mdbu) mode = M_LOCK;
        else if (!(mode == M_UP ? mdbu : mdbd)) mode = M_IDLE;
        else if (k == RD || (k > RD && (k - RD) % RR == 0)) begin
          ei = mode == M_UP;
          ed = mode == M_DN;
        end
      end
      hu.push_back(bus.btn_up);
      hd.push_back(bus.btn_down);
      if (hu.size() > 16) begin void'(hu.pop_front()); void'(hd.pop_front()); end
      nu = mdbu ^ flip(hu, mdbu);
      nd = mdbd ^ flip(hd, mdbd);
      pu = mdbu; pd = mdbd; mdbu = nu; mdbd = nd;
    end
    expq.push_back({ei, ed, mdbu, mdbd});
  end
  always @(posedge clk) begin
    logic [3:0] e, g;
    #1;
    g = {bus.increment, bus.decrement, bus.btn_up_db, bus.btn_down_db};
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard edge %0d: got inc/dec/up_db/dn_db=%b expected %b", cyc, g, e);
      end
    end
    if (bus.increment) incq.push_back(cyc);
    if (bus.decrement) decq.push_back(cyc);
    if (bus.btn_up_db && !last_up) upr.push_back(cyc);
    last_up = bus.btn_up_db;
  end
  task automatic hold(input logic u, input logic d, input int n);
    bus.btn_up = u;
    bus.btn_down = d;
    repeat (n) @(negedge clk);
  endtask
  task automatic begin_scen(output int t0);
    incq.delete(); decq.delete(); upr.delete();
    t0 = cyc + 1;
  endtask
  task automatic check_q(input string name, input int got[$], input int want[$]);
    bit ok = got.size() == want.size();
    for (int i = 0; ok && i < want.size(); i++) ok = got[i] == want[i];
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got edges %p expected %p", name, got, want);
    end
  endtask
  task automatic rst_check(input string name);
    #1;
    n_checks++;
    if ({bus.increment, bus.decrement, bus.btn_up_db, bus.btn_down_db} !== 4'b0) begin
      n_fail++;
      $display("FAIL %s: got outputs %b expected 0000", name,
               {bus.increment, bus.decrement, bus.btn_up_db, bus.btn_down_db});
    end
  endtask
  initial begin
    int t0, t3;
    int none[$];
    bus.btn_up = 0;
    bus.btn_down = 0;
    @(negedge clk);
    rst_check("reset_state");
    repeat (2) @(negedge clk);
    reset = 0;
    hold(0, 0, 5);
    begin_scen(t0);
    hold(1, 0, 10); hold(0, 0, 30);
    check_q("single_press_inc", incq, '{t0 + 7});
    check_q("single_press_dec", decq, none);
    check_q("single_press_db_rise", upr, '{t0 + 6});
    begin_scen(t0);
    hold(1, 0, 3); hold(0, 0, 20);
    check_q("glitch_inc", incq, none);
    check_q("glitch_db_rise", upr, none);
    begin_scen(t0);
    hold(0, 1, 36); hold(0, 0, 20);
    check_q("repeat_dec", decq, '{t0 + 7, t0 + 23, t0 + 27, t0 + 31, t0 + 35, t0 + 39});
    check_q("repeat_inc", incq, none);
    begin_scen(t0);
    hold(1, 1, 12); hold(0, 1, 12); hold(0, 0, 12);
    t3 = cyc + 1;
    hold(0, 1, 12); hold(0, 0, 20);
    check_q("lockout_dec", decq, '{t3 + 7});
    check_q("lockout_inc", incq, none);
    begin_scen(t0);
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 0, 20);
    check_q("opposite_inc", incq, '{t0 + 7, t0 + 23});
    check_q("opposite_dec", decq, none);
    begin_scen(t0);
    hold(1, 0, 25);
    reset = 1;
    rst_check("reset_mid_hold");
    hold(1, 0, 5);
    reset = 0;
    hold(1, 0, 15); hold(0, 0, 20);
    check_q("reset_hold_inc", incq, '{t0 + 7, t0 + 23, t0 + 37});
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1;
        hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        reset = 0;
      end else hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 30));
    end
    hold(0, 0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
